alu_mc: RTL and testbench

- Parametrised, handshaked successor to the core single-cycle ALU.
- Keeps the same 4-bit opcode map. Registers every result behind a valid/ready output stage.
- Replaces the combinational MUL/DIV/MOD with iterative radix-2 units, with defined divide-by-zero and overflow results.
- Sits between the execute-stage operand muxes and writeback; the stall logic uses in_ready and busy.

---
 rtl/alu_mc.sv | 204 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered results and iterative MUL/DIV/REM.
// Ports:
//   clk, aresetn            clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake; instr, src_a, src_b sampled on accept
//   out_valid/out_ready     result handshake; result is registered
//   busy                    an iterative operation (MUL/DIV/FIX) is in progress
module alu_mc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      instr,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_EQ  = 4'h8;
  localparam logic [3:0] OP_NE  = 4'h9;
  localparam logic [3:0] OP_GE  = 4'hA;
  localparam logic [3:0] OP_LTU = 4'hB;
  localparam logic [3:0] OP_GEU = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;
  localparam logic [3:0] OP_DIV = 4'hE;
  localparam logic [3:0] OP_REM = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] acc_q;   // MUL accumulator / DIV partial remainder
  logic [XLEN-1:0] opa_q;   // MUL multiplicand / DIV dividend shifting into quotient
  logic [XLEN-1:0] opb_q;   // MUL multiplier / DIV divisor magnitude
  logic            mul_q, rem_q, neg_q_q, neg_r_q;

  // Request decode
  logic accept, is_mul, is_dv, div_zero, div_ovf, special;
  logic start_mul, start_div, fast, fix_write;
  logic [SHW-1:0] shamt;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (instr == OP_MUL);
  assign is_dv     = (instr == OP_DIV) || (instr == OP_REM);
  assign div_zero  = (src_b == '0);
  assign div_ovf   = (src_a == MIN_INT) && (src_b == '1);
  assign special   = is_dv && (div_zero || div_ovf);
  assign start_mul = accept && is_mul;
  assign start_div = accept && is_dv && !special;
  assign fast      = accept && !is_mul && (!is_dv || special);
  // FIX only writes once any held result has been taken
  assign fix_write = (state_q == S_FIX) && (!out_valid || out_ready);
  assign shamt     = src_b[SHW-1:0];

  // Single-cycle result
  logic [XLEN-1:0] alu_res, spec_res, fast_res;
  always_comb begin
    alu_res = '0;
    case (instr)
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SLL: alu_res = src_a << shamt;
      OP_SRA: alu_res = $signed(src_a) >>> shamt;
      OP_SLT: alu_res = XLEN'($signed(src_a) < $signed(src_b));
      OP_EQ:  alu_res = XLEN'(src_a == src_b);
      OP_NE:  alu_res = XLEN'(src_a != src_b);
      OP_GE:  alu_res = XLEN'($signed(src_a) >= $signed(src_b));
      OP_LTU: alu_res = XLEN'(src_a < src_b);
      OP_GEU: alu_res = XLEN'(src_a >= src_b);
      default: alu_res = '0;
    endcase
  end

  // Divide-by-zero and MIN_INT/-1 resolve without iterating
  assign spec_res = div_zero ? ((instr == OP_DIV) ? '1 : src_a)
                             : ((instr == OP_DIV) ? MIN_INT : '0);
  assign fast_res = is_dv ? spec_res : alu_res;

  // Operand magnitudes for the unsigned divider
  logic [XLEN-1:0] abs_a, abs_b;
  assign abs_a = src_a[XLEN-1] ? (~src_a + XLEN'(1)) : src_a;
  assign abs_b = src_b[XLEN-1] ? (~src_b + XLEN'(1)) : src_b;

  // One iteration of each unit
  logic [XLEN:0]   div_trial;
  logic            quo_bit;
  logic [XLEN-1:0] div_acc_n, div_opa_n, mul_acc_n, fix_val;
  assign div_trial = {acc_q, opa_q[XLEN-1]} - {1'b0, opb_q};
  assign quo_bit   = ~div_trial[XLEN];
  assign div_acc_n = quo_bit ? div_trial[XLEN-1:0] : {acc_q[XLEN-2:0], opa_q[XLEN-1]};
  assign div_opa_n = {opa_q[XLEN-2:0], quo_bit};
  assign mul_acc_n = opb_q[0] ? (acc_q + opa_q) : acc_q;

  // Sign fix-up applied in FIX
  always_comb begin
    fix_val = acc_q;
    if (!mul_q) begin
      if (rem_q) fix_val = neg_r_q ? (~acc_q + XLEN'(1)) : acc_q;
      else       fix_val = neg_q_q ? (~opa_q + XLEN'(1)) : opa_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_mul)      state_d = S_MUL;
        else if (start_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:        if (!out_valid || out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (aresetn && (state_q == S_IDLE) && (!out_valid || out_ready)) in_ready = 1'b1;
    if (state_q != S_IDLE) busy = 1'b1;
  end

  // Iterative datapath; counter holds at CNT_LAST rather than wrapping
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      mul_q   <= 1'b0;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start_mul) begin
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= src_a;
      opb_q <= src_b;
      mul_q <= 1'b1;
    end else if (start_div) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= abs_a;
      opb_q   <= abs_b;
      mul_q   <= 1'b0;
      rem_q   <= (instr == OP_REM);
      neg_q_q <= src_a[XLEN-1] ^ src_b[XLEN-1];
      neg_r_q <= src_a[XLEN-1];
    end else if (state_q == S_MUL) begin
      acc_q <= mul_acc_n;
      opa_q <= opa_q << 1;
      opb_q <= opb_q >> 1;
      if (cnt_q != CNT_LAST) cnt_q <= cnt_q + SHW'(1);
    end else if (state_q == S_DIV) begin
      acc_q <= div_acc_n;
      opa_q <= div_opa_n;
      if (cnt_q != CNT_LAST) cnt_q <= cnt_q + SHW'(1);
    end
  end

  // Result register with hold under backpressure
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (fast) begin
      out_valid <= 1'b1;
      result    <= fast_res;
    end else if (fix_write) begin
      out_valid <= 1'b1;
      result    <= fix_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven vectors through a scoreboard, plus reset-abort,
// backpressure and back-to-back sequences for alu_mc at XLEN=32.
module tb_alu_mc;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      instr;
  logic [XLEN-1:0] src_a, src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          wait_e;   // edges after the accept edge until out_valid rises
  } vec_t;

  vec_t            vecs[$];
  logic [31:0]     exp_q[$];
  logic [31:0]     exp_cur;
  int unsigned     pop_cyc[$];
  int unsigned     cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (aresetn) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got result %h with nothing expected", result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            n_bad++;
            $display("FAIL sb_result: got %h want %h", result, e);
          end
        end
        pop_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(exp_cur);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int w);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_res = e; v.wait_e = w;
    vecs.push_back(v);
  endfunction

  // Drive a request and hold it until accepted; returns 1 time unit after the accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    int w;
    instr = op; src_a = a; src_b = b; exp_cur = e; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready still %b after %0d cycles, want 1", in_ready, w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, with busy and in_ready seen on the way
  task automatic wait_out(output int n, output int bc, output int irs);
    n = 0; bc = 0; irs = 0;
    while (!out_valid && n < 200) begin
      if (busy) bc++;
      if (in_ready) irs++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, irs, base, t;

    // Single-cycle ops (wait 0) and iterative ops (wait XLEN+1)
    add(4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0);
    add(4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0);
    add(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
    add(4'h3, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0);
    add(4'h4, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 0);
    add(4'h5, 32'h00000001, 32'h0000003F, 32'h80000000, 0);
    add(4'h5, 32'h12345678, 32'h00000004, 32'h23456780, 0);
    add(4'h6, 32'h80000000, 32'h00000021, 32'hC0000000, 0);
    add(4'h6, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 0);
    add(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0);
    add(4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0);
    add(4'h8, 32'h00000005, 32'h00000005, 32'h00000001, 0);
    add(4'h9, 32'h00000005, 32'h00000005, 32'h00000000, 0);
    add(4'hA, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 0);
    add(4'hA, 32'h00000003, 32'h00000003, 32'h00000001, 0);
    add(4'hB, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
    add(4'hC, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0);
    add(4'hD, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 33);
    add(4'hD, 32'h00010000, 32'h00010000, 32'h00000000, 33);
    add(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    add(4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    add(4'hF, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    add(4'hE, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    add(4'hF, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
    add(4'hE, 32'h00000064, 32'h00000007, 32'h0000000E, 33);
    add(4'hF, 32'h00000064, 32'h00000007, 32'h00000002, 33);
    add(4'hE, 32'h80000000, 32'h00000002, 32'hC0000000, 33);
    add(4'hF, 32'h80000000, 32'h00000003, 32'hFFFFFFFE, 33);
    add(4'hE, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
    add(4'hF, 32'h00000005, 32'h00000000, 32'h00000005, 0);
    add(4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    add(4'hF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

    in_valid = 1'b0; instr = '0; src_a = '0; src_b = '0; exp_cur = '0; out_ready = 1'b1;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #9 aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Table sweep with out_ready held high
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res);
      wait_out(n, bc, irs);
      chk($sformatf("latency[%0d]", i), 32'(n), 32'(vecs[i].wait_e));
      chk($sformatf("busy_cycles[%0d]", i), 32'(bc), 32'(vecs[i].wait_e));
      chk($sformatf("in_ready_during_op[%0d]", i), 32'(irs), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a DIV at iteration 10
    issue(4'hE, 32'h000003E8, 32'h00000007, 32'h0000008E);
    repeat (10) @(posedge clk);
    #1;
    chk("div_busy_before_abort", 32'(busy), 32'd1);
    #2 aresetn = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rel_in_ready", 32'(in_ready), 32'd1);
    chk("abort_rel_out_valid", 32'(out_valid), 32'd0);
    n = 0;
    repeat (40) begin
      if (out_valid || busy) n++;
      @(posedge clk);
      #1;
    end
    chk("aborted_result_absent", 32'(n), 32'd0);

    // Backpressure: ADD result held, then consumed on the same edge SUB is accepted
    out_ready = 1'b0;
    issue(4'h0, 32'h00000002, 32'h00000003, 32'h00000005);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_valid[%0d]", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold_result[%0d]", k), result, 32'h00000005);
      chk($sformatf("hold_in_ready[%0d]", k), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    base = pop_cyc.size();
    out_ready = 1'b1;
    issue(4'h1, 32'h0000000A, 32'h00000003, 32'h00000007);
    chk("bp_add_consumed", 32'(pop_cyc.size() - base), 32'd1);
    chk("bp_sub_valid", 32'(out_valid), 32'd1);
    chk("bp_sub_result", result, 32'h00000007);
    @(posedge clk);
    #1;

    // Back-to-back ADD, MUL, XOR with in_valid kept high
    base = pop_cyc.size();
    issue(4'h0, 32'h00000001, 32'h00000002, 32'h00000003);
    issue(4'hD, 32'h00000006, 32'h00000007, 32'h0000002A);
    issue(4'h4, 32'h000000F0, 32'h0000000F, 32'h000000FF);
    t = 0;
    while (pop_cyc.size() < base + 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", 32'(pop_cyc.size() - base), 32'd3);
    if (pop_cyc.size() >= base + 3) begin
      // MUL is accepted on the edge that takes the ADD, then needs XLEN+1 more edges
      chk("b2b_mul_gap", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'(XLEN + 2));
      chk("b2b_xor_gap", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd1);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
